// File: rtl/fir_pkg.sv
// fir_pkg: width helpers shared by the symmetric FIR pipeline and its adder tree.
package fir_pkg;

  // Pre-adder output: sum of two N-bit samples.
  function automatic int unsigned pre_w(input int unsigned n);
    return n + 1;
  endfunction

  // Product of an (N+1)-bit pre-add and an N-bit coefficient.
  function automatic int unsigned prod_w(input int unsigned n);
    return 2 * n + 1;
  endfunction

  // Accumulator wide enough for TAPS/2 full-scale products.
  function automatic int unsigned sum_w(input int unsigned n, input int unsigned taps);
    return 2 * n + 1 + $clog2(taps / 2);
  endfunction

  // Coefficient index width, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned taps);
    return ($clog2(taps / 2) < 1) ? 1 : $clog2(taps / 2);
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree: registered unsigned sum of COUNT equal-width terms.
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int unsigned COUNT = 4,
  parameter int unsigned IN_W  = 33,
  parameter int unsigned OUT_W = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  terms [COUNT],
  output logic [OUT_W-1:0] sum
);

  logic [OUT_W-1:0] total;

  // Combinational sum of all terms; OUT_W is sized so this cannot overflow.
  always_comb begin
    total = '0;
    for (int unsigned i = 0; i < COUNT; i++) begin
      total = total + OUT_W'(terms[i]);
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else begin
      sum <= total;
    end
  end

endmodule

// File: rtl/fir_sym_pipe.sv
// fir_sym_pipe: pipelined symmetric FIR (pre-add, multiply, sum, scale).
// Optional macro FIR_SAT_EN: saturate the scaled output instead of wrapping.
module fir_sym_pipe
  import fir_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned TAPS  = 8,
  parameter int unsigned SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N-1:0]              X,
  input  logic                      coef_we,
  input  logic [addr_w(TAPS)-1:0]   coef_addr,
  input  logic [N-1:0]              coef_wdata,
  output logic [N-1:0]              Y,
  output logic                      y_valid
);

  localparam int unsigned HALF = TAPS / 2;
  localparam int unsigned PW   = pre_w(N);
  localparam int unsigned MW   = prod_w(N);
  localparam int unsigned SW   = sum_w(N, TAPS);

  // The oldest tap is only ever seen through the pre-add of the updated
  // line, so TAPS-1 stored samples plus the live input cover all taps.
  logic [N-1:0]  dly      [TAPS-1];
  logic [N-1:0]  dly_next [TAPS];
  logic [PW-1:0] pre_next [HALF];
  logic [PW-1:0] pre      [HALF];
  logic [N-1:0]  coef     [HALF];
  logic [MW-1:0] prod     [HALF];
  logic [SW-1:0] sum;
  logic          v1, v2, v3;
  logic [N-1:0]  scaled;

  // Updated delay line and folded pre-adds for the incoming sample.
  always_comb begin
    dly_next[0] = X;
    for (int unsigned i = 1; i < TAPS; i++) begin
      dly_next[i] = dly[i-1];
    end
    for (int unsigned k = 0; k < HALF; k++) begin
      pre_next[k] = PW'(dly_next[k]) + PW'(dly_next[TAPS-1-k]);
    end
  end

  // Stage 1: shift delay line and capture pre-adds on accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS - 1; i++) dly[i] <= '0;
      for (int unsigned k = 0; k < HALF; k++) pre[k] <= '0;
      v1 <= 1'b0;
    end else begin
      if (en) begin
        for (int unsigned i = 0; i < TAPS - 1; i++) dly[i] <= dly_next[i];
        for (int unsigned k = 0; k < HALF; k++) pre[k] <= pre_next[k];
      end
      v1 <= en;
    end
  end

  // Coefficient file; indices beyond the unique half are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < HALF; k++) coef[k] <= '0;
    end else if (coef_we && (32'(coef_addr) < HALF)) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  // Stage 2: multiply pre-adds by current coefficients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < HALF; k++) prod[k] <= '0;
      v2 <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < HALF; k++) begin
        prod[k] <= MW'(pre[k]) * MW'(coef[k]);
      end
      v2 <= v1;
    end
  end

  fir_adder_tree #(
    .COUNT (HALF),
    .IN_W  (MW),
    .OUT_W (SW)
  ) u_tree (
    .clk   (clk),
    .rst   (rst),
    .terms (prod),
    .sum   (sum)
  );

  // Valid tag travelling alongside the adder tree register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0;
    end else begin
      v3 <= v2;
    end
  end

`ifdef FIR_SAT_EN
  logic [SW-1:0] shifted;

  // Scale and clamp to full scale.
  always_comb begin
    shifted = sum >> SHIFT;
    scaled  = (|shifted[SW-1:N]) ? '1 : shifted[N-1:0];
  end
`else
  // Scale and keep the low N bits.
  always_comb begin
    scaled = N'(sum >> SHIFT);
  end
`endif

  // Output register: Y holds between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= v3;
      if (v3) Y <= scaled;
    end
  end

endmodule
